hazard_control_unit: RTL and testbench

- Stall/flush control for the 5-stage pipeline; companion to the forwarding control unit.
- Forwarding resolves RAW hazards by pulling results back into EX; this block covers the cases forwarding cannot: load-use, taken-branch squash, data-memory wait and HLT drain.
- It drives PC/IF_ID write enables, bubble insertion into ID/EX, and pipeline flushes.
- It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_control_unit.sv | 139 +++++++++++++
 tb/tb_hazard_control_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/halt control for the 5-stage pipeline
//
// Purpose: covers the hazards forwarding cannot resolve (load-use, taken-branch
// squash, data-memory wait, HLT drain) and keeps a saturating stall-cycle counter.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   ID_EX_MemRead/RegisterRt     load currently in EX and its destination register
//   IF_ID_RegisterRs/Rt, UsesRs/Rt  source registers of the instruction in ID
//   Branch_Taken                 EX resolved a taken branch/jump this cycle
//   Mem_Busy                     data memory not ready, whole pipe freezes
//   MEM_WB_Halt                  HLT has reached WB
//   PC_Write, IF_ID_Write        front-end register write enables
//   ID_EX_Bubble                 zero control bits entering ID/EX
//   IF_ID_Flush, ID_EX_Flush     squash IF/ID, ID/EX to NOP
//   Pipe_Freeze                  hold EX/MEM and MEM/WB
//   Halted                       processor halted
//   Stall_Count                  saturating count of cycles with PC_Write=0

module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [3:0]       ID_EX_RegisterRt,
    input  logic [3:0]       IF_ID_RegisterRs,
    input  logic [3:0]       IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRs,
    input  logic             IF_ID_UsesRt,
    input  logic             Branch_Taken,
    input  logic             Mem_Busy,
    input  logic             MEM_WB_Halt,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Pipe_Freeze,
    output logic             Halted,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Flush cycles still owed after the branch cycle itself.
    localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;
    logic       lu;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign lu = ID_EX_MemRead && (ID_EX_RegisterRt != 4'd0) &&
                ((IF_ID_UsesRs && (IF_ID_RegisterRs == ID_EX_RegisterRt)) ||
                 (IF_ID_UsesRt && (IF_ID_RegisterRt == ID_EX_RegisterRt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (state == HALTED) begin
            state_nxt = HALTED;
        end else if (MEM_WB_Halt) begin
            state_nxt = HALTED;
            fcnt_nxt  = 2'd0;
        end else if (Mem_Busy) begin
            // Freeze: the branch (if any) stays in EX and is presented again later.
            state_nxt = state;
        end else if (Branch_Taken) begin
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                fcnt_nxt  = RELOAD;
            end else begin
                state_nxt = RUN;
                fcnt_nxt  = 2'd0;
            end
        end else if (state == FLUSH) begin
            if (fcnt <= 2'd1) begin
                state_nxt = RUN;
                fcnt_nxt  = 2'd0;
            end else begin
                fcnt_nxt  = fcnt - 2'd1;
            end
        end
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        Halted       = 1'b0;
        if (state == HALTED) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Halted      = 1'b1;
        end else if (Mem_Busy) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (state == FLUSH) begin
            // ID holds a wrong-path instruction, so a load-use match is irrelevant.
            IF_ID_Flush = 1'b1;
        end else if (lu) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Stall_Count <= '0;
        end else if (!PC_Write && (Stall_Count != {CNT_W{1'b1}})) begin
            Stall_Count <= Stall_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    localparam int FC      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_read = 1'b0;
    logic [3:0]    ex_rt = 4'd0;
    logic [3:0]    id_rs = 4'd0;
    logic [3:0]    id_rt = 4'd0;
    logic          uses_rs = 1'b0;
    logic          uses_rt = 1'b0;
    logic          br = 1'b0;
    logic          busy = 1'b0;
    logic          hlt = 1'b0;
    logic          pc_write, ifid_write, bubble, ifid_flush, idex_flush, freeze, halted;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_control_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_EX_MemRead    (mem_read),
        .ID_EX_RegisterRt (ex_rt),
        .IF_ID_RegisterRs (id_rs),
        .IF_ID_RegisterRt (id_rt),
        .IF_ID_UsesRs     (uses_rs),
        .IF_ID_UsesRt     (uses_rt),
        .Branch_Taken     (br),
        .Mem_Busy         (busy),
        .MEM_WB_Halt      (hlt),
        .PC_Write         (pc_write),
        .IF_ID_Write      (ifid_write),
        .ID_EX_Bubble     (bubble),
        .IF_ID_Flush      (ifid_flush),
        .ID_EX_Flush      (idex_flush),
        .Pipe_Freeze      (freeze),
        .Halted           (halted),
        .Stall_Count      (stall_count)
    );

    // {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, Halted}
    wire [6:0] outv = {pc_write, ifid_write, bubble, ifid_flush, idex_flush, freeze, halted};

    int checks = 0;
    int fails  = 0;

    // Reference model: halted flag, number of squash cycles still owed, stall tally.
    bit m_halted     = 1'b0;
    int m_flush_left = 0;
    int m_stalls     = 0;
    bit m_ok         = 1'b0;

    function automatic logic [6:0] model_out();
        bit hit_rs, hit_rt, lu;
        hit_rs = uses_rs && (id_rs == ex_rt);
        hit_rt = uses_rt && (id_rt == ex_rt);
        lu     = mem_read && (ex_rt != 0) && (hit_rs || hit_rt);
        if (m_halted)          return 7'b0000001;
        if (busy)              return 7'b0000010;
        if (br)                return 7'b1101100;
        if (m_flush_left > 0)  return 7'b1101000;
        if (lu)                return 7'b0010000;
        return 7'b1100000;
    endfunction

    always @(posedge clk) begin
        logic [6:0] e;
        e = model_out();
        if (rst) begin
            m_halted     = 1'b0;
            m_flush_left = 0;
            m_stalls     = 0;
            m_ok         = 1'b1;
        end else begin
            if (!e[6] && m_stalls < CNT_MAX) m_stalls++;
            if (m_halted) begin
                m_halted = 1'b1;
            end else if (hlt) begin
                m_halted     = 1'b1;
                m_flush_left = 0;
            end else if (busy) begin
                m_flush_left = m_flush_left;
            end else if (br) begin
                m_flush_left = FC - 1;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            checks++;
            if (outv !== model_out()) begin
                fails++;
                $display("FAIL model_outputs t=%0t got=%b exp=%b", $time, outv, model_out());
            end
            checks++;
            if (stall_count !== CW'(m_stalls)) begin
                fails++;
                $display("FAIL model_stall_count t=%0t got=%0d exp=%0d", $time, stall_count, m_stalls);
            end
        end
    end

    task automatic set_in(input bit mr, input logic [3:0] ert, input logic [3:0] rs,
                          input logic [3:0] rt, input bit urs, input bit urt,
                          input bit b, input bit bz, input bit h);
        mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        uses_rs = urs; uses_rt = urt; br = b; busy = bz; hlt = h;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check the current cycle against literal values, then advance to the next cycle.
    task automatic expect_cycle(input string name, input logic [6:0] e, input int ec);
        @(negedge clk);
        checks++;
        if (outv !== e) begin
            fails++;
            $display("FAIL %s outputs got=%b exp=%b", name, outv, e);
        end
        checks++;
        if (stall_count !== CW'(ec)) begin
            fails++;
            $display("FAIL %s stall_count got=%0d exp=%0d", name, stall_count, ec);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        expect_cycle("reset_idle", 7'b1100000, 0);
        set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
        expect_cycle("load_r0_no_hazard", 7'b1100000, 0);
        set_in(1, 3, 3, 5, 0, 1, 0, 0, 0);
        expect_cycle("unused_rs_no_hazard", 7'b1100000, 0);
        set_in(1, 3, 3, 0, 1, 0, 0, 0, 0);
        expect_cycle("load_use_stall", 7'b0010000, 0);
        idle();
        expect_cycle("load_use_resume", 7'b1100000, 1);

        set_in(1, 3, 3, 0, 1, 0, 1, 0, 0);
        expect_cycle("branch_first", 7'b1101100, 1);
        set_in(1, 3, 3, 0, 1, 0, 0, 0, 0);
        expect_cycle("branch_second_lu_ignored", 7'b1101000, 1);
        expect_cycle("after_flush_lu_stalls", 7'b0010000, 1);
        idle();
        expect_cycle("after_flush_idle", 7'b1100000, 2);

        set_in(1, 3, 3, 0, 1, 0, 1, 1, 0);
        expect_cycle("busy_1", 7'b0000010, 2);
        expect_cycle("busy_2", 7'b0000010, 3);
        expect_cycle("busy_3", 7'b0000010, 4);
        set_in(1, 3, 3, 0, 1, 0, 1, 0, 0);
        expect_cycle("busy_drop_branch", 7'b1101100, 5);
        idle();
        expect_cycle("busy_drop_flush2", 7'b1101000, 5);
        expect_cycle("busy_drop_idle", 7'b1100000, 5);

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_cycle("halt_pulse", 7'b1100000, 5);
        idle();
        expect_cycle("halted_1", 7'b0000001, 5);
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        expect_cycle("halted_2", 7'b0000001, 6);
        idle();
        rst = 1'b1;
        expect_cycle("halted_in_reset", 7'b0000001, 7);
        rst = 1'b0;
        expect_cycle("after_halt_reset", 7'b1100000, 0);

        set_in(1, 7, 0, 7, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            expect_cycle("saturation", 7'b0010000, (i < CNT_MAX) ? i : CNT_MAX);
        idle();
        expect_cycle("saturated_hold", 7'b1100000, CNT_MAX);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            mem_read = 1'($urandom_range(0, 1));
            ex_rt    = 4'($urandom_range(0, 3));
            id_rs    = 4'($urandom_range(0, 3));
            id_rt    = 4'($urandom_range(0, 3));
            uses_rs  = 1'($urandom_range(0, 1));
            uses_rt  = 1'($urandom_range(0, 1));
            br       = ($urandom_range(0, 5) == 0);
            busy     = ($urandom_range(0, 4) == 0);
            hlt      = ($urandom_range(0, 79) == 0);
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
